// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl
// Reset sequencer. Takes one board-level reset and releases N_STG downstream
// reset domains one at a time, in index order. Each stage is held in reset for
// STG_DLY cycles, then released. The sequencer then waits for that stage's
// ready acknowledge before moving to the next stage. A per-stage watchdog
// re-asserts a stage that never acknowledges and parks the sequencer in an
// error state until a soft restart or a hard reset.
// All outputs come straight from flops.

module rst_seq_ctrl #(
    parameter int N_STG   = 4,
    parameter int STG_DLY = 4,
    parameter int TO_CYC  = 1024,
    parameter int CNT_W   = 16,
    localparam int SW     = (N_STG > 1) ? $clog2(N_STG) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst,
    input  logic [N_STG-1:0] stg_ack,
    output logic [N_STG-1:0] rst_out,
    output logic             busy,
    output logic             all_rdy,
    output logic             err,
    output logic [SW-1:0]    err_stg
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_DELAY = 2'd0;  // holding rst_out[stg] before release
    localparam logic [1:0] ST_WAIT  = 2'd1;  // rst_out[stg] released, waiting for ack
    localparam logic [1:0] ST_RUN   = 2'd2;  // every stage released and acknowledged
    localparam logic [1:0] ST_ERR   = 2'd3;  // watchdog expired, parked

    localparam logic [SW-1:0]    LAST_STG = SW'(N_STG - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STG_DLY - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);

    // ------------------------------------------------------------------
    // Registers and their next values
    // ------------------------------------------------------------------
    logic [1:0]       state_reg,   state_next;
    logic [SW-1:0]    stg_reg,     stg_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [N_STG-1:0] rst_out_reg, rst_out_next;
    logic             busy_reg,    busy_next;
    logic             all_rdy_reg, all_rdy_next;
    logic             err_reg,     err_next;
    logic [SW-1:0]    err_stg_reg, err_stg_next;

    // ------------------------------------------------------------------
    // Stage decode and event qualifiers
    // ------------------------------------------------------------------
    logic [N_STG-1:0] stg_sel;      // one-hot of the stage currently being sequenced
    logic             ack_cur;      // acknowledge of the current stage only
    logic             dly_done;     // last DELAY cycle for the current stage
    logic             to_done;      // last WAIT_ACK cycle before the watchdog fires
    logic             release_now;  // this edge releases rst_out[stg]
    logic             timeout_now;  // this edge declares the current stage failed

    // Decoding stg into a one-hot vector keeps the ack mux and the per-bit
    // reset logic free of variable part-selects, which also stays safe when
    // N_STG is not a power of two.
    generate
        for (genvar gi = 0; gi < N_STG; gi++) begin : g_sel
            assign stg_sel[gi] = (stg_reg == SW'(gi));
        end
    endgenerate

    // Acks from stages that are not being waited on never reach the FSM.
    assign ack_cur     = |(stg_ack & stg_sel);
    assign dly_done    = (cnt_reg == DLY_LAST);
    assign to_done     = (cnt_reg == TO_LAST);
    assign release_now = !soft_rst && (state_reg == ST_DELAY) && dly_done;
    assign timeout_now = !soft_rst && (state_reg == ST_WAIT) && !ack_cur && to_done;

    // ------------------------------------------------------------------
    // Per-stage reset output next value
    // Soft restart re-asserts everything. Otherwise only the selected stage
    // can change: it is released at the end of its DELAY and re-asserted if
    // its watchdog expires. Stages below it stay released and stages above
    // it stay in reset, which gives the strict release order.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_STG; gi++) begin : g_rst_bit
            assign rst_out_next[gi] = soft_rst                      ? 1'b1 :
                                      (stg_sel[gi] && release_now)  ? 1'b0 :
                                      (stg_sel[gi] && timeout_now)  ? 1'b1 :
                                                                      rst_out_reg[gi];
        end
    endgenerate

    // Sequencer next-state, counter and status flags; soft_rst overrides all.
    always_comb begin
        state_next   = state_reg;
        stg_next     = stg_reg;
        cnt_next     = cnt_reg;
        busy_next    = busy_reg;
        all_rdy_next = all_rdy_reg;
        err_next     = err_reg;
        err_stg_next = err_stg_reg;

        if (soft_rst) begin
            // Held here for as long as soft_rst stays high; the count does
            // not start until the first edge with soft_rst low.
            state_next   = ST_DELAY;
            stg_next     = '0;
            cnt_next     = '0;
            busy_next    = 1'b1;
            all_rdy_next = 1'b0;
            err_next     = 1'b0;
            err_stg_next = '0;
        end else begin
            case (state_reg)
                ST_DELAY: begin
                    if (dly_done) begin
                        cnt_next   = '0;
                        state_next = ST_WAIT;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end

                ST_WAIT: begin
                    if (ack_cur) begin
                        if (stg_reg == LAST_STG) begin
                            state_next   = ST_RUN;
                            all_rdy_next = 1'b1;
                            busy_next    = 1'b0;
                        end else begin
                            stg_next   = stg_reg + SW'(1);
                            cnt_next   = '0;
                            state_next = ST_DELAY;
                        end
                    end else if (to_done) begin
                        state_next   = ST_ERR;
                        err_next     = 1'b1;
                        err_stg_next = stg_reg;
                        busy_next    = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end

                // Acks are one-way: once running, later ack activity is ignored.
                ST_RUN: begin
                    state_next = ST_RUN;
                end

                // Parked until soft_rst or rst.
                ST_ERR: begin
                    state_next = ST_ERR;
                end

                default: begin
                    state_next = ST_DELAY;
                end
            endcase
        end
    end

    // Control registers: the board reset restarts the sequence from stage 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_DELAY;
            stg_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            stg_reg   <= stg_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Output registers: the board reset drives every stage reset high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_out_reg <= '1;
            busy_reg    <= 1'b1;
            all_rdy_reg <= 1'b0;
            err_reg     <= 1'b0;
            err_stg_reg <= '0;
        end else begin
            rst_out_reg <= rst_out_next;
            busy_reg    <= busy_next;
            all_rdy_reg <= all_rdy_next;
            err_reg     <= err_next;
            err_stg_reg <= err_stg_next;
        end
    end

    assign rst_out = rst_out_reg;
    assign busy    = busy_reg;
    assign all_rdy = all_rdy_reg;
    assign err     = err_reg;
    assign err_stg = err_stg_reg;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl
// Bench for the reset sequencer. A timeline model (edge counter plus the edge
// at which the current stage entered its delay or was released) predicts every
// output on every cycle. Directed scenarios add literal expectations that pin
// the model; a randomized phase follows.

module tb_rst_seq_ctrl;

    localparam int N = 4;
    localparam int D = 4;
    localparam int T = 16;

    localparam int M_SEQ = 0;
    localparam int M_RUN = 1;
    localparam int M_ERR = 2;

    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic         soft_rst = 1'b0;
    logic [N-1:0] stg_ack  = '0;
    logic [N-1:0] rst_out;
    logic         busy;
    logic         all_rdy;
    logic         err;
    logic [1:0]   err_stg;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: timeline of the sequence
    int n_edge     = 0;  // clock edges seen while out of reset
    int m_mode     = M_SEQ;
    int m_stg      = 0;
    int m_released = 0;  // current stage already released
    int m_start    = 0;  // edge at which the current stage entered its delay
    int m_rel_edge = 0;  // edge at which the current stage was released

    rst_seq_ctrl #(
        .N_STG   (N),
        .STG_DLY (D),
        .TO_CYC  (T),
        .CNT_W   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .soft_rst (soft_rst),
        .stg_ack  (stg_ack),
        .rst_out  (rst_out),
        .busy     (busy),
        .all_rdy  (all_rdy),
        .err      (err),
        .err_stg  (err_stg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_restart();
        m_mode     = M_SEQ;
        m_stg      = 0;
        m_released = 0;
        m_start    = n_edge;
        m_rel_edge = 0;
    endtask

    // Advance the timeline by one clock edge with the inputs sampled at it.
    task automatic model_step(input logic sr, input logic [N-1:0] ack);
        n_edge++;
        if (sr) begin
            model_restart();
        end else if (m_mode == M_SEQ) begin
            if (m_released == 0) begin
                if (n_edge - m_start == D) begin
                    m_released = 1;
                    m_rel_edge = n_edge;
                end
            end else if (ack[m_stg]) begin
                if (m_stg == N - 1) begin
                    m_mode = M_RUN;
                end else begin
                    m_stg      = m_stg + 1;
                    m_released = 0;
                    m_start    = n_edge;
                end
            end else if (n_edge - m_rel_edge == T) begin
                m_mode = M_ERR;
            end
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] er;
        for (int k = 0; k < N; k++) begin
            if (k < m_stg)      er[k] = 1'b0;
            else if (k > m_stg) er[k] = 1'b1;
            else if (m_mode == M_RUN) er[k] = 1'b0;
            else if (m_mode == M_ERR) er[k] = 1'b1;
            else er[k] = (m_released == 0);
        end
        check("rst_out", 32'(rst_out), 32'(er));
        check("busy",    32'(busy),    32'(m_mode == M_SEQ));
        check("all_rdy", 32'(all_rdy), 32'(m_mode == M_RUN));
        check("err",     32'(err),     32'(m_mode == M_ERR));
        check("err_stg", 32'(err_stg), (m_mode == M_ERR) ? 32'(m_stg) : 32'd0);
    endtask

    // One clock: apply inputs, take the edge, step the model, compare.
    task automatic cycle(input logic sr, input logic [N-1:0] ack);
        soft_rst = sr;
        stg_ack  = ack;
        @(posedge clk);
        model_step(sr, ack);
        #1;
        compare_model();
    endtask

    // Asynchronous reset between edges, held across two edges, released mid-cycle.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_restart();
        check("async_rst_out", 32'(rst_out), 32'hF);
        compare_model();
        repeat (2) @(posedge clk);
        #1;
        compare_model();
        rst = 1'b0;
        model_restart();
    endtask

    initial begin
        logic [N-1:0] mask;
        #1;

        // 1: all acks present, releases 5 edges apart, ready on edge 20
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            cycle(1'b0, 4'hF);
            if (e == 3)  check("t1_e3_rst_out",  32'(rst_out), 32'hF);
            if (e == 4)  check("t1_e4_rst_out",  32'(rst_out), 32'hE);
            if (e == 9)  check("t1_e9_rst_out",  32'(rst_out), 32'hC);
            if (e == 14) check("t1_e14_rst_out", 32'(rst_out), 32'h8);
            if (e == 19) begin
                check("t1_e19_rst_out", 32'(rst_out), 32'h0);
                check("t1_e19_all_rdy", 32'(all_rdy), 32'd0);
            end
            if (e == 20) begin
                check("t1_e20_all_rdy", 32'(all_rdy), 32'd1);
                check("t1_e20_busy",    32'(busy),    32'd0);
            end
        end

        // 2: ack[2] arrives 7 cycles after rst_out[2] falls, ready on edge 27
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            cycle(1'b0, (e >= 22) ? 4'hF : 4'hB);
            if (e == 26) check("t2_e26_all_rdy", 32'(all_rdy), 32'd0);
            if (e == 27) check("t2_e27_all_rdy", 32'(all_rdy), 32'd1);
        end

        // 3: ack[1] never arrives, watchdog fires 16 edges after release
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            cycle(1'b0, 4'h1);
            if (e == 24) check("t3_e24_err", 32'(err), 32'd0);
            if (e == 25 || e == 30) begin
                check("t3_err",     32'(err),     32'd1);
                check("t3_err_stg", 32'(err_stg), 32'd1);
                check("t3_rst_out", 32'(rst_out), 32'hE);
                check("t3_busy",    32'(busy),    32'd0);
                check("t3_all_rdy", 32'(all_rdy), 32'd0);
            end
        end

        // 4: soft restart from ERR, ready 20 edges after soft_rst falls
        for (int e = 1; e <= 3; e++) cycle(1'b1, 4'hF);
        check("t4_rst_out", 32'(rst_out), 32'hF);
        check("t4_err",     32'(err),     32'd0);
        check("t4_busy",    32'(busy),    32'd1);
        for (int e = 1; e <= 20; e++) begin
            cycle(1'b0, 4'hF);
            if (e == 19) check("t4_e19_all_rdy", 32'(all_rdy), 32'd0);
            if (e == 20) check("t4_e20_all_rdy", 32'(all_rdy), 32'd1);
        end

        // 6: in RUN, ack activity is ignored
        for (int e = 1; e <= 12; e++) begin
            cycle(1'b0, (e == 1) ? 4'h0 : 4'($urandom));
            check("t6_all_rdy", 32'(all_rdy), 32'd1);
            check("t6_rst_out", 32'(rst_out), 32'h0);
        end

        // 5: hard reset while waiting on stage 2, then a full sequence
        do_reset();
        for (int e = 1; e <= 17; e++) cycle(1'b0, 4'hB);
        check("t5_pre_rst_out", 32'(rst_out), 32'h8);
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            cycle(1'b0, 4'hF);
            if (e == 4)  check("t5_e4_rst_out",  32'(rst_out), 32'hE);
            if (e == 20) check("t5_e20_all_rdy", 32'(all_rdy), 32'd1);
        end

        // Randomized phase: random acks, occasional stuck stage, soft/hard resets
        mask = 4'hF;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                mask = 4'hF;
                if ($urandom_range(0, 2) == 0) mask[$urandom_range(0, 3)] = 1'b0;
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle(($urandom_range(0, 59) == 0), 4'($urandom) & mask);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
